// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core and the iterative multiply/divide unit.
// The core drives the request side; the unit drives busy and the write-back side.
interface muldiv_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic [4:0]      rd_in;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic [4:0]      rd_out;
   logic            wb_en;

   modport master (
      output start, funct3, rs1_val, rs2_val, rd_in,
      input  busy, done, result, rd_out, wb_en
   );

   modport slave (
      input  start, funct3, rs1_val, rs2_val, rd_in,
      output busy, done, result, rd_out, wb_en
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: XLEN shift-add / restoring-divide steps on operand
// magnitudes, one sign-fix cycle, then a one-cycle done pulse. Latency is data-independent.
module muldiv_unit #(
   parameter int unsigned XLEN = 32
) (
   input logic           clk,
   input logic           reset,
   muldiv_unit_if.slave  bus
);
   localparam int unsigned    CntW     = $clog2(XLEN);
   localparam logic [CntW-1:0] LastIter = CntW'(XLEN - 1);

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e          r_state;
   logic [CntW-1:0] r_cnt;
   logic [2:0]      r_op;
   logic            r_neg;
   logic [XLEN-1:0] r_hi;
   logic [XLEN-1:0] r_lo;
   logic [XLEN-1:0] r_opnd;
   logic [4:0]      r_rd;
   logic [4:0]      r_rd_out;
   logic [XLEN-1:0] r_result;
   logic            r_done;
   logic            r_wb_en;

   // Operand decode at capture time
   logic            w_is_div;
   logic            w_a_signed;
   logic            w_b_signed;
   logic            w_a_neg;
   logic            w_b_neg;
   logic            w_b_zero;
   logic            w_neg_in;
   logic [XLEN-1:0] w_mag_a;
   logic [XLEN-1:0] w_mag_b;

   assign w_is_div   = bus.funct3[2];
   assign w_a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                       (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
   assign w_b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                       (bus.funct3 == 3'b110);
   assign w_a_neg    = w_a_signed && bus.rs1_val[XLEN-1];
   assign w_b_neg    = w_b_signed && bus.rs2_val[XLEN-1];
   assign w_b_zero   = (bus.rs2_val == '0);
   assign w_mag_a    = w_a_neg ? -bus.rs1_val : bus.rs1_val;
   assign w_mag_b    = w_b_neg ? -bus.rs2_val : bus.rs2_val;

   // Divide-by-zero leaves an all-ones quotient unnegated and the dividend as remainder,
   // which the plain restoring loop already produces once the quotient sign is suppressed.
   always_comb begin
      w_neg_in = w_a_neg ^ w_b_neg;
      if (w_is_div) begin
         if (bus.funct3[1]) w_neg_in = w_a_neg;
         else               w_neg_in = (w_a_neg ^ w_b_neg) && !w_b_zero;
      end
   end

   // One iteration step
   logic [XLEN:0]   w_sum;
   logic [XLEN:0]   w_shift;
   logic            w_ge;
   logic [XLEN-1:0] w_diff;

   assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
   assign w_shift = {r_hi, r_lo[XLEN-1]};
   assign w_ge    = (w_shift >= {1'b0, r_opnd});
   assign w_diff  = w_shift[XLEN-1:0] - r_opnd;

   // Sign correction and result selection
   logic [2*XLEN-1:0] w_prod;
   logic [2*XLEN-1:0] w_prod_s;
   logic [XLEN-1:0]   w_quo;
   logic [XLEN-1:0]   w_rem;
   logic [XLEN-1:0]   w_fix_res;

   assign w_prod   = {r_hi, r_lo};
   assign w_prod_s = r_neg ? -w_prod : w_prod;
   assign w_quo    = r_neg ? -r_lo : r_lo;
   assign w_rem    = r_neg ? -r_hi : r_hi;

   always_comb begin
      w_fix_res = '0;
      case (r_op)
         3'b000:                 w_fix_res = w_prod_s[XLEN-1:0];
         3'b001, 3'b010, 3'b011: w_fix_res = w_prod_s[2*XLEN-1:XLEN];
         3'b100, 3'b101:         w_fix_res = w_quo;
         default:                w_fix_res = w_rem;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= StIdle;
         r_cnt    <= '0;
         r_done   <= 1'b0;
         r_wb_en  <= 1'b0;
         r_result <= '0;
         r_rd_out <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               r_done  <= 1'b0;
               r_wb_en <= 1'b0;
               if (bus.start) begin
                  r_op    <= bus.funct3;
                  r_neg   <= w_neg_in;
                  r_rd    <= bus.rd_in;
                  r_hi    <= '0;
                  // Multiply: lo holds multiplier, opnd the multiplicand.
                  // Divide: lo holds dividend (becomes quotient), opnd the divisor.
                  r_lo    <= w_is_div ? w_mag_a : w_mag_b;
                  r_opnd  <= w_is_div ? w_mag_b : w_mag_a;
                  r_cnt   <= '0;
                  r_state <= StCalc;
               end
            end
            StCalc: begin
               if (r_op[2]) begin
                  r_hi <= w_ge ? w_diff : w_shift[XLEN-1:0];
                  r_lo <= {r_lo[XLEN-2:0], w_ge};
               end else begin
                  {r_hi, r_lo} <= {w_sum, r_lo[XLEN-1:1]};
               end
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == LastIter) r_state <= StFix;
            end
            StFix: begin
               r_result <= w_fix_res;
               r_rd_out <= r_rd;
               r_done   <= 1'b1;
               r_wb_en  <= (r_rd != 5'd0);
               r_state  <= StDone;
            end
            StDone: begin
               r_done  <= 1'b0;
               r_wb_en <= 1'b0;
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign bus.busy   = (r_state != StIdle);
   assign bus.done   = r_done;
   assign bus.wb_en  = r_wb_en;
   assign bus.result = r_result;
   assign bus.rd_out = r_rd_out;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected write-backs from an arithmetic
// reference model, a negedge monitor pops and compares them on every done pulse.
module tb_muldiv_unit;
   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   muldiv_unit_if #(.XLEN(32)) bus ();

   muldiv_unit #(.XLEN(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          due;
   } exp_t;

   exp_t exp_q[$];

   function automatic logic [31:0] ref_model(logic [2:0] f, logic [31:0] a, logic [31:0] b);
      longint          sa, sb, sp;
      longint unsigned ua, ub, up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (f)
         3'd0: begin up = ua * ub; return up[31:0]; end
         3'd1: begin sp = sa * sb; return sp[63:32]; end
         3'd2: begin sp = sa * longint'(ub); return sp[63:32]; end
         3'd3: begin up = ua * ub; return up[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            sp = sa / sb;
            return sp[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            sp = sa % sb;
            return sp[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         5:       return $urandom_range(0, 15);
         default: return $urandom;
      endcase
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, req, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      exp_t e;
      if (reset !== 1'b1) begin
         if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("result", bus.result, e.res);
               check("rd_out", {27'b0, bus.rd_out}, {27'b0, e.rd});
               check("wb_en", {31'b0, bus.wb_en}, {31'b0, (e.rd != 5'd0)});
               check("latency", cyc, e.due);
            end
         end else if (bus.wb_en !== 1'b0) begin
            check("wb_en_without_done", {31'b0, bus.wb_en}, 32'd0);
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (bus.busy !== 1'b0 && n < 200) begin
         @(posedge clk) #1;
         n++;
      end
      if (n >= 200) check("idle_timeout", 32'd1, 32'd0);
   endtask

   // Returns one step after the accepting edge N; operands are scrambled afterwards.
   task automatic issue(logic [2:0] f, logic [31:0] a, logic [31:0] b, logic [4:0] rd, bit push);
      exp_t e;
      wait_idle();
      bus.start   = 1'b1;
      bus.funct3  = f;
      bus.rs1_val = a;
      bus.rs2_val = b;
      bus.rd_in   = rd;
      if (push) begin
         e.res = ref_model(f, a, b);
         e.rd  = rd;
         e.due = cyc + 1 + 33;
         exp_q.push_back(e);
      end
      @(posedge clk) #1;
      bus.start   = 1'b0;
      bus.funct3  = 3'($urandom);
      bus.rs1_val = $urandom;
      bus.rs2_val = $urandom;
      bus.rd_in   = 5'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk) #1;
         n++;
      end
      if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
   endtask

   initial begin
      bit saw_done;
      reset       = 1'b1;
      bus.start   = 1'b0;
      bus.funct3  = 3'd0;
      bus.rs1_val = '0;
      bus.rs2_val = '0;
      bus.rd_in   = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("rst_busy", {31'b0, bus.busy}, 32'd0);
         check("rst_done", {31'b0, bus.done}, 32'd0);
         check("rst_wb_en", {31'b0, bus.wb_en}, 32'd0);
         check("rst_result", bus.result, 32'd0);
         check("rst_rd_out", {27'b0, bus.rd_out}, 32'd0);
      end
      @(posedge clk) #1;

      // MUL with cycle-by-cycle busy/done profile after the accepting edge.
      issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1);
      for (int k = 0; k <= 34; k++) begin
         @(negedge clk);
         check("mul_busy", {31'b0, bus.busy}, {31'b0, (k <= 33)});
         check("mul_done", {31'b0, bus.done}, {31'b0, (k == 33)});
      end
      drain();

      issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 1'b1);
      issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1);
      issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b1);
      issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b1);
      issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1);
      issue(3'd5, 32'd100, 32'd0, 5'd7, 1'b1);
      issue(3'd7, 32'd100, 32'd0, 5'd8, 1'b1);
      issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b1);
      issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b1);
      issue(3'd0, 32'd3, 32'd5, 5'd0, 1'b1);
      drain();

      // Second start at N+10 must be dropped.
      issue(3'd0, 32'd6, 32'd9, 5'd11, 1'b1);
      repeat (9) @(posedge clk) #1;
      bus.start   = 1'b1;
      bus.funct3  = 3'd5;
      bus.rs1_val = 32'd1000;
      bus.rs2_val = 32'd3;
      bus.rd_in   = 5'd12;
      @(posedge clk) #1;
      bus.start = 1'b0;
      drain();
      repeat (40) @(posedge clk) #1;

      // Reset mid-DIV: abort, no done pulse, then a clean operation.
      issue(3'd4, 32'd12345, 32'd7, 5'd13, 1'b0);
      repeat (14) @(posedge clk) #1;
      reset = 1'b1;
      @(posedge clk) #1;
      reset = 1'b0;
      check("abort_busy", {31'b0, bus.busy}, 32'd0);
      check("abort_result", bus.result, 32'd0);
      check("abort_rd_out", {27'b0, bus.rd_out}, 32'd0);
      saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) saw_done = 1'b1;
      end
      check("abort_no_done", {31'b0, saw_done}, 32'd0);
      @(posedge clk) #1;
      issue(3'd4, 32'd12345, 32'd7, 5'd14, 1'b1);
      drain();

      for (int i = 0; i < 200; i++) begin
         issue(3'($urandom), pick_operand(), pick_operand(), 5'($urandom_range(0, 31)), 1'b1);
      end
      drain();
      repeat (5) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit beside the register file.
- Consumes the two register-file read values (rs1, rs2) and produces a write-back value plus destination index for the register-file write port.
- The core holds the instruction while busy is high. done, result, rd_out and wb_en drive data_in, write_ad and write_en directly.
- Fixed, data-independent latency.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported. It also sets the iteration count.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_val  input  XLEN  operand A (dividend / multiplicand)
- rs2_val  input  XLEN  operand B (divisor / multiplier)
- rd_in  input  5  destination register index
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle result-valid pulse
- result  output  XLEN  result; held from DONE until the next accepted start
- rd_out  output  5  captured rd_in; held like result
- wb_en  output  1  done AND (rd_out != 0); register-file write enable

Behaviour:
- Reset (clk edge with reset=1):
  - state=IDLE; busy=0, done=0, wb_en=0, result=0, rd_out=0; iteration counter=0.
  - Reset aborts any operation mid-flight; no done pulse follows.
  - Reset has priority over start.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - If start=1 at edge N: capture funct3, rs1_val, rs2_val, rd_in; counter=0; go to CALC.
  - Later input changes are ignored.
- CALC: one iteration per edge, XLEN edges (N+1..N+32), then FIX.
  - Multiply: shift-add on magnitudes into a 64-bit product.
  - Divide: restoring shift-subtract on magnitudes, giving quotient and remainder.
- FIX: one edge (N+33). Applies sign correction, selects the result, then goes to DONE.
  - MUL: low 32 bits. MULH: high 32, signed x signed. MULHSU: high 32, signed rs1 x unsigned rs2. MULHU: high 32, unsigned.
  - DIV/REM: quotient sign = sign(A) XOR sign(B); remainder sign = sign(A); truncate toward zero.
  - Divide by zero: DIV/DIVU quotient=0xFFFFFFFF; REM/REMU=dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV=0x80000000, REM=0.
  - Special cases use the same latency as normal operations.
- DONE: done=1 for exactly the cycle between edges N+33 and N+34. wb_en as defined above. Next edge goes to IDLE.
- Latency: start sampled at edge N; the consumer samples done=1 at edge N+34. Initiation interval is 35 cycles minimum.
- start while busy=1 (CALC/FIX/DONE): ignored, not queued.
- rd_in=0: the operation executes and done pulses, but wb_en=0.
- result and rd_out change only at the FIX->DONE edge and on reset.

Test Plan:
- Reset, then idle 5 cycles -> busy=0, done=0, wb_en=0, result=0, rd_out=0 throughout.
- MUL 7 x 0xFFFFFFFD, rd=5, start at edge N -> done and wb_en high only at edge N+34; result=0xFFFFFFEB; rd_out=5; busy high from N through N+33.
- High products:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF
- Divide, including special cases:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF
  - DIVU 100 / 0 -> 0xFFFFFFFF; REMU 100 / 0 -> 100
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0
  - All cases above complete at N+34.
- Protocol:
  - Start pulsed again at N+10 with different operands -> ignored; the first result is unchanged.
  - rd_in=0 -> done=1 with wb_en=0.
  - Operands toggled after N -> no effect on result.
- Reset at N+15 mid-DIV -> IDLE next edge; busy=0, result=0; no done pulse within the next 40 cycles. A new start afterward completes normally 34 cycles later.
